// File: rtl/symbol_packer_pkg.sv
// symbol_packer_pkg: shared decoder word geometry used by the packer and the lane splitter
package symbol_packer_pkg;
  localparam int DEC_SYM_W = 2;
  localparam int DEC_SYMS_PER_WORD = 8;
  localparam int DEC_WORD_W = DEC_SYM_W * DEC_SYMS_PER_WORD;
endpackage

// File: rtl/symbol_packer_word_fifo.sv
// word_fifo: first-word-fall-through buffer with level; a pop on the same edge frees room for a push when full
module word_fifo
  import symbol_packer_pkg::*;
#(
  parameter int W = DEC_WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic pop_ok, push_ok;
  always_comb begin
    empty = level == '0;
    full = level == (AW+1)'(DEPTH);
    pop_ok = pop && !empty;
    push_ok = push && (!full || pop_ok);
    dout = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/symbol_packer.sv
// symbol_packer: packs encoded symbols LSB-first into words and queues committed words in a FWFT buffer
module symbol_packer
  import symbol_packer_pkg::*;
#(
  parameter int SYM_W = DEC_SYM_W,
  parameter int SYMS_PER_WORD = DEC_SYMS_PER_WORD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SYM_W-1:0]                sym_in,
  input  logic                            sym_valid,
  input  logic                            frame_start,
  input  logic                            flush,
  input  logic                            word_rd,
  output logic [SYM_W*SYMS_PER_WORD-1:0]  data_out,
  output logic                            word_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);
  localparam int WORD_W = SYM_W * SYMS_PER_WORD;
  localparam int SLOT_W = $clog2(SYMS_PER_WORD);
  logic [SLOT_W-1:0] slot, base_slot, next_slot;
  logic [WORD_W-1:0] partial, base_word, merged;
  logic last, do_flush, push, full, empty;
  // frame_start wipes the partial word before the same-cycle symbol is merged in
  always_comb begin
    base_slot = frame_start ? '0 : slot;
    base_word = frame_start ? '0 : partial;
    merged = sym_valid ? base_word | (WORD_W'(sym_in) << (base_slot * SYM_W)) : base_word;
    last = sym_valid && base_slot == SLOT_W'(SYMS_PER_WORD - 1);
    do_flush = flush && !frame_start && (sym_valid || base_slot != '0);
    push = last || do_flush;
    next_slot = push ? '0 : base_slot + SLOT_W'(sym_valid);
    word_valid = !empty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      partial <= '0;
      overflow <= 1'b0;
    end else begin
      slot <= next_slot;
      partial <= push ? '0 : merged;
      overflow <= overflow | (push && full && !word_rd);
    end
  end
  word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(word_rd),
    .din(merged),
    .dout(data_out),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_symbol_packer.sv
// tb_symbol_packer: directed and random stimulus checked against a queue-based word model
module tb_symbol_packer;
  logic clk = 1'b0;
  logic rst, sym_valid, frame_start, flush, word_rd;
  logic [1:0] sym_in;
  logic [15:0] data_out;
  logic word_valid, overflow;
  logic [2:0] fifo_level;
  int checks = 0;
  int failures = 0;
  int part[$];
  logic [15:0] q[$];
  bit ovf = 1'b0;

  symbol_packer dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
    .frame_start(frame_start), .flush(flush), .word_rd(word_rd),
    .data_out(data_out), .word_valid(word_valid), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pack();
    logic [15:0] w = '0;
    foreach (part[k]) w |= 16'(part[k]) << (2 * k);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit [1:0] s, input bit fs, input bit fl, input bit rd);
    bit pop, commit;
    rst = r; sym_valid = v; sym_in = s; frame_start = fs; flush = fl; word_rd = rd;
    if (r) begin
      part.delete(); q.delete(); ovf = 1'b0;
    end else begin
      pop = rd && q.size() > 0;
      if (fs) part.delete();
      if (v) part.push_back(int'(s));
      commit = part.size() == 8 || (fl && !fs && part.size() > 0);
      if (pop) void'(q.pop_front());
      if (commit) begin
        if (q.size() < 4) q.push_back(pack());
        else ovf = 1'b1;
        part.delete();
      end
    end
    @(posedge clk); #1;
    chk("word_valid", word_valid, q.size() > 0);
    chk("data_out", data_out, q.size() > 0 ? q[0] : 16'h0);
    chk("fifo_level", fifo_level, q.size());
    chk("overflow", overflow, ovf);
  endtask

  task automatic sy(input bit [1:0] s, input bit rd = 1'b0);
    cyc(1'b0, 1'b1, s, 1'b0, 1'b0, rd);
  endtask

  task automatic idle(input bit rd);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, rd);
  endtask

  task automatic reset();
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sym_valid = 1'b0; frame_start = 1'b0; flush = 1'b0; word_rd = 1'b0; sym_in = '0;
    reset();
    chk("reset_valid", word_valid, 0);
    chk("reset_data", data_out, 0);
    chk("reset_level", fifo_level, 0);
    idle(1'b1);
    chk("empty_pop_level", fifo_level, 0);
    for (int i = 0; i < 8; i++) sy(2'(i % 4));
    chk("e4e4_data", data_out, 16'hE4E4);
    chk("e4e4_level", fifo_level, 1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) sy(2'd3);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("flush_data", data_out, 16'h003F);
    idle(1'b1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("noop_flush_level", fifo_level, 0);
    for (int i = 0; i < 7; i++) sy(2'd1);
    cyc(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    chk("slot0_restart", data_out, 16'h5555);
    chk("flush_last_once", fifo_level, 1);
    idle(1'b1);
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 8; k++) sy(2'((w + 1) % 4));
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", data_out, 16'h5555);
    reset();
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 8; k++) sy(2'((w + 1) % 4));
    for (int k = 0; k < 7; k++) sy(2'd0);
    sy(2'd0, 1'b1);
    chk("full_pushpop_level", fifo_level, 4);
    chk("full_pushpop_ovf", overflow, 0);
    chk("full_pushpop_head", data_out, 16'hAAAA);
    reset();
    for (int k = 0; k < 5; k++) sy(2'd1);
    cyc(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) sy(2'd0);
    chk("frame_start_data", data_out, 16'h0002);
    chk("frame_start_level", fifo_level, 1);
    reset();
    for (int k = 0; k < 16; k++) sy(2'(k / 8 + 1));
    for (int k = 0; k < 4; k++) sy(2'd3);
    reset();
    chk("rst_valid", word_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    sy(2'd3);
    for (int k = 0; k < 7; k++) sy(2'd0);
    chk("rst_restart", data_out, 16'h0003);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(99) == 0, $urandom_range(3) != 0, 2'($urandom),
          $urandom_range(19) == 0, $urandom_range(9) == 0, $urandom_range(2) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/symbol_packer.md
SYMBOL_PACKER -- requirements
Module: symbol_packer

Interface
REQ-001 SHALL have parameter SYM_W, default 2, meaning bits per encoded symbol (rate-1/2 pair).
REQ-002 SHALL have parameter SYMS_PER_WORD, default 8, meaning symbols packed per output word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning committed-word buffer entries (power of 2).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sym_in  input  SYM_W  encoded symbol, sampled when sym_valid=1.
REQ-007 SHALL have port sym_valid  input  1  sym_in carries a symbol this cycle.
REQ-008 SHALL have port frame_start  input  1  discard any partial word, restart packing at slot 0.
REQ-009 SHALL have port flush  input  1  commit partial word zero-padded.
REQ-010 SHALL have port word_rd  input  1  downstream pops head word.
REQ-011 SHALL have port data_out  output  SYM_W*SYMS_PER_WORD  head word (16 bits at default), feeds the word input of the 8-lane splitter.
REQ-012 SHALL have port word_valid  output  1  FIFO not empty.
REQ-013 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  committed words held.
REQ-014 SHALL have port overflow  output  1  sticky: a committed word was dropped.

Function
REQ-015 SHALL place the k-th accepted symbol of a word (k=0..7) at data bits [2k+1:2k], LSB first.
REQ-016 SHALL keep a slot counter 0..7; each accepted symbol advances it; wrap 7->0 commits the word.
REQ-017 SHALL write the 8th symbol together with the 7 held symbols into the FIFO on the same edge; word_valid rises the following cycle (latency 1 clock from 8th symbol).
REQ-018 SHALL operate the FIFO first-word-fall-through: data_out = head entry whenever word_valid=1, else all-zero.
REQ-019 SHALL pop on word_rd=1 with word_valid=1; word_rd with FIFO empty is ignored, level stays 0.
REQ-020 SHALL, on simultaneous push and pop, update level by net 0, including when full (pop frees the slot first).
REQ-021 SHALL, on push when full without pop, drop the new word, leave FIFO unchanged, set overflow=1.
REQ-022 SHALL, on frame_start=1, discard partial contents; if sym_valid=1 same cycle, that symbol lands in slot 0 and slot becomes 1, else slot becomes 0.
REQ-023 SHALL, on flush=1 with slot>0 (after including any same-cycle symbol), commit the word with unfilled slots zero; slot becomes 0.
REQ-024 SHALL treat flush with slot=0 and no symbol as no-op; a symbol filling slot 7 with flush commits exactly once.
REQ-025 SHALL give frame_start priority over flush when both asserted; flush ignored.
REQ-026 SHALL never alter committed FIFO entries on frame_start or flush.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, clear slot counter, partial register, FIFO pointers, overflow; data_out=0, word_valid=0, fifo_level=0.
REQ-028 SHALL let rst override all other inputs in the same cycle; a partial word or queued words mid-operation are lost.

Structure
REQ-029 SHALL take SYM_W, SYMS_PER_WORD, and the derived word width from the shared decoder package used by the splitter.
REQ-030 SHALL implement the buffer as one sub-module word_fifo (parameterised width/depth, FWFT, level, full/empty).

Verification
REQ-031 SHALL check: 8 consecutive symbols 0,1,2,3,0,1,2,3 -> next cycle word_valid=1, data_out=16'hE4E4, level=1.
REQ-032 SHALL check: 3 symbols 3,3,3 then flush -> data_out=16'h003F, slot=0.
REQ-033 SHALL check: 5 words pushed with word_rd=0 -> level=4, overflow=1, head equals first word.
REQ-034 SHALL check: full FIFO, push with word_rd=1 -> level stays 4, overflow stays 0.
REQ-035 SHALL check: 5 symbols, then frame_start with sym_valid, sym_in=2 plus 7 symbols 0 -> data_out=16'h0002.
REQ-036 SHALL check: rst asserted with 2 words queued and slot=4 -> next cycle word_valid=0, level=0, overflow=0, next word starts at slot 0.
